// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly scheduling slice.
// Holds the datapath lane width, default transform geometry, the scheduler
// state encoding and the default address widths derived from it.
package fft_pkg;

    localparam int unsigned DW           = 21;
    localparam int unsigned LOG2N_DEF    = 4;
    localparam int unsigned PIPE_LAT_DEF = 3;

    localparam int unsigned ADDR_W_DEF   = LOG2N_DEF;
    localparam int unsigned TW_W_DEF     = LOG2N_DEF - 1;
    localparam int unsigned STAGE_W_DEF  = $clog2(LOG2N_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address mapping.
// Ports:
//   s  - pass number
//   k  - butterfly index within the pass (0 .. N/2-1)
//   a  - upper operand address  ((k >> s) << (s+1)) | (k mod 2^s)
//   b  - lower operand address  a + 2^s
//   tw - twiddle ROM index      (k mod 2^s) << (LOG2N-1-s)
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF,
    localparam int unsigned SW   = (LOG2N > 1) ? $clog2(LOG2N) : 1,
    localparam int unsigned KW   = LOG2N - 1
) (
    input  logic [SW-1:0]    s,
    input  logic [KW-1:0]    k,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [KW-1:0]    tw
);

    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [SW:0]      tw_sh;

    always_comb begin
        kx    = {1'b0, k};
        span  = LOG2N'(1) << s;
        pos   = kx & (span - 1'b1);
        grp   = kx >> s;
        // Shift by s then by one: a single (s+1) shift amount would wrap in SW bits.
        a     = ((grp << s) << 1) | pos;
        b     = a + span;
        tw_sh = (SW + 1)'(LOG2N - 1) - (SW + 1)'(s);
        tw    = KW'(pos << tw_sh);
    end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Butterfly issue scheduler for an in-place N-point radix-2 DIT FFT.
// Issues one butterfly per cycle over LOG2N passes, drains the datapath
// pipeline between passes and replays the issued addresses as write-back
// strobes PIPE_LAT cycles later.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - begin a transform (sampled in IDLE only)
//   hold                 - pause issue while running
//   busy                 - high in RUN and DRAIN
//   done                 - one-cycle pulse after the final write-back
//   rd_en, rd_addr_a/b   - operand read strobe and addresses
//   tw_addr              - twiddle ROM index, valid with rd_en
//   wr_en, wr_addr_a/b   - delayed write-back strobe and addresses
//   stage                - current pass number
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N    = LOG2N_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
    localparam int unsigned SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_addr,
    output logic               wr_en,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b,
    output logic [SW-1:0]      stage
);

    localparam int unsigned KW  = LOG2N - 1;
    localparam int unsigned CW  = $clog2(PIPE_LAT + 1);
    localparam int unsigned DLW = 2 * LOG2N + 1;

    state_t          state, state_nxt;
    logic [SW-1:0]   s, s_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [LOG2N-1:0] a, b;
    logic [KW-1:0]    tw;

    logic [DLW-1:0]   dly [PIPE_LAT];

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .s  (s),
        .k  (k),
        .a  (a),
        .b  (b),
        .tw (tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            k     <= k_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        cnt_nxt   = cnt;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    s_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (!hold) begin
                    rd_en = 1'b1;
                    if (k == '1) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CW'(PIPE_LAT);
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    if (s != SW'(LOG2N - 1)) begin
                        s_nxt     = s + 1'b1;
                        k_nxt     = '0;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FIN;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
                s_nxt     = '0;
                k_nxt     = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are only presented in RUN (frozen across hold), zero otherwise.
    assign rd_addr_a = (state == RUN) ? a  : '0;
    assign rd_addr_b = (state == RUN) ? b  : '0;
    assign tw_addr   = (state == RUN) ? tw : '0;
    assign stage     = s;

    // Write-back delay line; rd_en travels with the addresses so hold bubbles survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = dly[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
module tb_fft_bfly_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_addr;
    logic [1:0] stage;

    fft_bfly_scheduler #(
        .LOG2N    (4),
        .PIPE_LAT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    localparam int MAXC = 128;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
    } wr_t;

    wr_t sb[$];
    wr_t it;

    int checks = 0;
    int errors = 0;

    // per-cycle expectations and drive schedule
    logic       e_busy [MAXC];
    logic       e_done [MAXC];
    logic       e_rd   [MAXC];
    logic       e_chk  [MAXC];
    logic [3:0] e_a    [MAXC];
    logic [3:0] e_b    [MAXC];
    logic [2:0] e_tw   [MAXC];
    logic [1:0] e_stage[MAXC];
    logic       drv_start[MAXC];
    logic       drv_hold [MAXC];
    logic       drv_rst  [MAXC];

    int wr_count, last_wr, done_count, done_cycle;

    task automatic clear_exp(input int from);
        for (int c = from; c < MAXC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_chk[c] = 0;
            e_a[c] = '0; e_b[c] = '0; e_tw[c] = '0; e_stage[c] = '0;
        end
    endtask

    task automatic clear_drv();
        for (int c = 0; c < MAXC; c++) begin
            drv_start[c] = 0; drv_hold[c] = 0; drv_rst[c] = 0;
        end
        wr_count = 0; last_wr = -1; done_count = 0; done_cycle = -1;
        sb.delete();
    endtask

    // Expected schedule: passes enumerate upper operands in ascending order
    // (address bit p clear), hold cycles stall issue inside [hlo, hhi].
    task automatic add_transform(input int t0, input int hlo, input int hhi);
        int c;
        int span;
        c = t0 + 1;
        for (int p = 0; p < 4; p++) begin
            span = 1 << p;
            for (int a = 0; a < 16; a++) begin
                if (((a >> p) & 1) == 0) begin
                    while (c >= hlo && c <= hhi) begin
                        e_busy[c] = 1; e_chk[c] = 1; e_rd[c] = 0;
                        e_a[c] = 4'(a); e_b[c] = 4'(a + span);
                        e_tw[c] = 3'((a % span) << (3 - p)); e_stage[c] = 2'(p);
                        c++;
                    end
                    e_busy[c] = 1; e_chk[c] = 1; e_rd[c] = 1;
                    e_a[c] = 4'(a); e_b[c] = 4'(a + span);
                    e_tw[c] = 3'((a % span) << (3 - p)); e_stage[c] = 2'(p);
                    c++;
                end
            end
            for (int d = 0; d < 3; d++) begin
                e_busy[c] = 1; e_stage[c] = 2'(p);
                c++;
            end
        end
        e_done[c] = 1;
    endtask

    task automatic run_cycles(input string tag, input int n);
        logic exp_w;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst_n = !drv_rst[c];
            start = drv_start[c];
            hold  = drv_hold[c];
            @(negedge clk);
            if (drv_rst[c]) sb.delete();
            if (e_rd[c]) sb.push_back('{c + 3, e_a[c], e_b[c]});

            checks++;
            if (busy !== e_busy[c]) begin
                errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, busy, e_busy[c]);
            end
            checks++;
            if (done !== e_done[c]) begin
                errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, c, done, e_done[c]);
            end
            checks++;
            if (rd_en !== e_rd[c]) begin
                errors++;
                $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", tag, c, rd_en, e_rd[c]);
            end
            if (e_chk[c]) begin
                checks++;
                if (rd_addr_a !== e_a[c] || rd_addr_b !== e_b[c] || tw_addr !== e_tw[c]) begin
                    errors++;
                    $display("FAIL %s rd_addr cyc=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
                             tag, c, rd_addr_a, rd_addr_b, tw_addr, e_a[c], e_b[c], e_tw[c]);
                end
            end
            if (e_busy[c]) begin
                checks++;
                if (stage !== e_stage[c]) begin
                    errors++;
                    $display("FAIL %s stage cyc=%0d got=%0d exp=%0d", tag, c, stage, e_stage[c]);
                end
            end
            if (drv_rst[c]) begin
                checks++;
                if ({rd_addr_a, rd_addr_b, tw_addr, stage, wr_addr_a, wr_addr_b} !== '0) begin
                    errors++;
                    $display("FAIL %s rst_zero cyc=%0d got a=%0d b=%0d tw=%0d st=%0d wa=%0d wb=%0d exp all 0",
                             tag, c, rd_addr_a, rd_addr_b, tw_addr, stage, wr_addr_a, wr_addr_b);
                end
            end

            exp_w = (sb.size() > 0) && (sb[0].cyc == c);
            checks++;
            if (wr_en !== exp_w) begin
                errors++;
                $display("FAIL %s wr_en cyc=%0d got=%b exp=%b", tag, c, wr_en, exp_w);
            end
            if (exp_w) begin
                it = sb.pop_front();
                if (wr_en === 1'b1) begin
                    checks++;
                    if (wr_addr_a !== it.a || wr_addr_b !== it.b) begin
                        errors++;
                        $display("FAIL %s wr_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                                 tag, c, wr_addr_a, wr_addr_b, it.a, it.b);
                    end
                end
            end
            if (wr_en === 1'b1) begin
                wr_count++;
                last_wr = c;
            end
            if (done === 1'b1) begin
                done_count++;
                done_cycle = c;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending_writes got=%0d exp=0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset strobes got=%b exp=0000", {busy, done, rd_en, wr_en});
        end
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_addr, stage, wr_addr_a, wr_addr_b} !== '0) begin
            errors++;
            $display("FAIL reset addrs got a=%0d b=%0d tw=%0d st=%0d wa=%0d wb=%0d exp all 0",
                     rd_addr_a, rd_addr_b, tw_addr, stage, wr_addr_a, wr_addr_b);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL idle strobes got=%b exp=0000", {busy, done, rd_en, wr_en});
        end
    endtask

    task automatic test_basic();
        clear_drv(); clear_exp(0);
        drv_start[0]  = 1;
        drv_start[10] = 1;  // ignored while busy
        add_transform(0, -1, -1);
        run_cycles("basic", 50);
        checks++;
        if (wr_count != 32) begin
            errors++;
            $display("FAIL basic wr_count got=%0d exp=32", wr_count);
        end
        checks++;
        if (last_wr != 44) begin
            errors++;
            $display("FAIL basic last_wr got=%0d exp=44", last_wr);
        end
        checks++;
        if (done_count != 1 || done_cycle != 45) begin
            errors++;
            $display("FAIL basic done got count=%0d cyc=%0d exp count=1 cyc=45", done_count, done_cycle);
        end
    endtask

    task automatic test_hold();
        clear_drv(); clear_exp(0);
        drv_start[0] = 1;
        for (int c = 4; c <= 6; c++) drv_hold[c] = 1;
        add_transform(0, 4, 6);
        run_cycles("hold", 52);
        checks++;
        if (done_cycle != 48) begin
            errors++;
            $display("FAIL hold done_cycle got=%0d exp=48", done_cycle);
        end
        checks++;
        if (wr_count != 32) begin
            errors++;
            $display("FAIL hold wr_count got=%0d exp=32", wr_count);
        end
    endtask

    task automatic test_abort();
        clear_drv(); clear_exp(0);
        drv_start[0] = 1;
        add_transform(0, -1, -1);
        clear_exp(20);
        for (int c = 20; c <= 24; c++) drv_rst[c] = 1;
        drv_start[26] = 1;
        add_transform(26, -1, -1);
        run_cycles("abort", 76);
        checks++;
        if (done_count != 1 || done_cycle != 71) begin
            errors++;
            $display("FAIL abort done got count=%0d cyc=%0d exp count=1 cyc=71", done_count, done_cycle);
        end
    endtask

    task automatic test_back_to_back();
        clear_drv(); clear_exp(0);
        for (int c = 0; c <= 46; c++) drv_start[c] = 1;
        add_transform(0, -1, -1);
        add_transform(46, -1, -1);
        run_cycles("b2b", 96);
        checks++;
        if (done_count != 2 || done_cycle != 91) begin
            errors++;
            $display("FAIL b2b done got count=%0d last=%0d exp count=2 last=91", done_count, done_cycle);
        end
        checks++;
        if (wr_count != 64) begin
            errors++;
            $display("FAIL b2b wr_count got=%0d exp=64", wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
- Sequences a single shared radix-2 butterfly datapath (21-bit real/imag lanes) through every pass of an N-point in-place decimation-in-time FFT, part of the Hilbert-transform chain.
- Each cycle it issues one butterfly:
  - read addresses for the two operands (a, b),
  - the twiddle ROM index,
  - the matching write-back addresses after a fixed pipeline delay.
- It inserts drain cycles between passes so no pass reads a location before the previous pass has written it.

Parameters:
- LOG2N, 4, log2 of FFT length N (N = 16 by default); N/2 butterflies per pass, LOG2N passes.
- PIPE_LAT, 3, cycles from rd_en to the corresponding wr_en (memory read + twiddle multiply + butterfly + register); must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin transform; sampled only in IDLE
- hold  input  1  pause issue in RUN (back-pressure from sample memory arbiter)
- busy  output  1  high from first issue cycle through last drain cycle
- done  output  1  single-cycle pulse after final write-back
- rd_en  output  1  operand read strobe
- rd_addr_a  output  LOG2N  address of upper operand
- rd_addr_b  output  LOG2N  address of lower operand (= rd_addr_a + span)
- tw_addr  output  LOG2N-1  twiddle ROM index, valid with rd_en
- wr_en  output  1  write-back strobe for both butterfly outputs
- wr_addr_a  output  LOG2N  destination of real_outa/imag_outa
- wr_addr_b  output  LOG2N  destination of real_outb/imag_outb
- stage  output  clog2(LOG2N)  current pass number, for debug/scaling control

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, all counters 0; outputs busy, done, rd_en and wr_en are 0; all address outputs, tw_addr and stage are 0. Asserting rst_n low mid-transform aborts immediately, flushes the delay line (no further wr_en) and produces no done.
- State machine IDLE -> RUN -> DRAIN -> (RUN | FIN) -> IDLE:
  - IDLE: start=1 at an edge -> RUN with s=0, k=0.
  - RUN: rd_en=1 unless hold=1.
    - hold=1: rd_en=0 and k/s are frozen; the delay line keeps shifting.
    - On each issue with k = N/2-1: -> DRAIN with drain counter = PIPE_LAT.
    - Otherwise k increments.
  - DRAIN: rd_en=0; count down PIPE_LAT cycles; hold ignored.
    - At end, if s < LOG2N-1: s++, k=0, -> RUN.
    - Else -> FIN.
  - FIN: done=1 for exactly one cycle; busy=0; -> IDLE.
- start is ignored outside IDLE. start held high continuously restarts on the cycle after FIN.
- Address generation for pass s, butterfly k:
  - span = 2^s
  - pos = k mod span
  - grp = k >> s
  - a = (grp << (s+1)) | pos
  - b = a + span
  - tw_addr = pos << (LOG2N-1-s)
  - Widths are exact and there is no wrap: a, b < N by construction.
- Write-back: {rd_en, a, b} enters a PIPE_LAT-deep shift register. wr_en/wr_addr_a/wr_addr_b equal the values issued PIPE_LAT cycles earlier, so bubbles caused by hold are preserved.
- Timing:
  - Per pass: N/2 issue cycles (+ hold cycles) + PIPE_LAT drain cycles.
  - First read of pass s+1 is strictly later than the last write of pass s.
  - No read and write to the same address ever occur in one cycle.
- busy=1 in RUN and DRAIN only.

Decomposition:
- Shared package fft_pkg holds DW=21, default LOG2N and PIPE_LAT, the state enum (IDLE, RUN, DRAIN, FIN) and the address-width localparams.
- One natural sub-module, fft_addr_gen: a combinational (s, k) -> (a, b, tw_addr) mapping, reusable by the IFFT pass and testable in isolation.
- Write-back delay line is kept inline.

Test Plan:
- Default params, start pulse at cycle 0, hold=0:
  - pass 0 issues at cycles 1-8, drain 9-11;
  - pass 1 issues at 12-19, drain 20-22;
  - pass 2 issues at 23-30, drain 31-33;
  - pass 3 issues at 34-41, drain 42-44;
  - done=1 at cycle 45 only; busy=1 over cycles 1-44.
- Address check:
  - pass 0: a=0,2,...,14; b=a+1; tw=0.
  - pass 1: a=0,1,4,5,8,9,12,13; b=a+2; tw=0,4,0,4,...
  - pass 3: a=k, b=k+8, tw=k.
- Write-back: every wr_en/wr_addr pair equals the rd_en/rd_addr pair exactly 3 cycles earlier; 32 writes in total; no wr_en after cycle 44.
- hold=1 for cycles 4-6 of pass 0: rd_en=0 and addresses frozen at k=3; wr_en shows a matching 3-cycle gap at cycles 7-9; done is delayed to cycle 48.
- rst_n low at cycle 20, high at cycle 25: outputs zero immediately and asynchronously; no done; a new start at cycle 26 replays the first scenario offset by 26 cycles.
- start asserted while busy (cycle 10) is ignored. start held high continuously gives done at 45 and the next pass-0 issue at cycle 47.
